// File: rtl/axis_vote_aligner_if.sv
// AXI-Stream style beat bundle used on every upstream and downstream lane
// of the vote aligner.
interface axis_vote_aligner_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_vote_aligner.sv
// Three-lane skew-absorbing aligner: each classifier lane is buffered in its
// own FIFO and triples are released together only when all lanes have a head.
module axis_vote_aligner #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    axis_vote_aligner_if.slave         s_axis_0,
    axis_vote_aligner_if.slave         s_axis_1,
    axis_vote_aligner_if.slave         s_axis_2,
    axis_vote_aligner_if.master        m_axis_0,
    axis_vote_aligner_if.master        m_axis_1,
    axis_vote_aligner_if.master        m_axis_2,
    input  logic                       err_clr,
    output logic                       tlast_mismatch,
    output logic [15:0]                triple_cnt
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int EW    = DATA_WIDTH + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [2:0]            s_valid;
    logic [2:0]            s_last;
    logic [2:0]            s_ready;
    logic [2:0]            m_ready;
    logic [DATA_WIDTH-1:0] s_data   [3];

    logic [PTR_W-1:0]      wr_ptr   [3];
    logic [PTR_W-1:0]      rd_ptr   [3];
    logic [EW-1:0]         mem      [3][FIFO_DEPTH];
    logic [EW-1:0]         head     [3];

    logic [2:0]            full;
    logic [2:0]            empty;
    logic [2:0]            push;
    logic [2:0]            head_last;
    logic                  m_valid;
    logic                  pop;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign s_valid = {s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};
    assign s_last  = {s_axis_2.tlast,  s_axis_1.tlast,  s_axis_0.tlast};
    assign m_ready = {m_axis_2.tready, m_axis_1.tready, m_axis_0.tready};
    assign s_data[0] = s_axis_0.tdata;
    assign s_data[1] = s_axis_1.tdata;
    assign s_data[2] = s_axis_2.tdata;

    // Full uses the extra wrap bit: same slot index, opposite lap.
    for (genvar k = 0; k < 3; k++) begin : g_lane
        assign full[k]      = (wr_ptr[k][AW] != rd_ptr[k][AW]) &&
                              (wr_ptr[k][AW-1:0] == rd_ptr[k][AW-1:0]);
        assign empty[k]     = (wr_ptr[k] == rd_ptr[k]);
        assign s_ready[k]   = rst_n & ~full[k];
        assign push[k]      = s_valid[k] & s_ready[k];
        assign head[k]      = mem[k][rd_ptr[k][AW-1:0]];
        assign head_last[k] = head[k][DATA_WIDTH];
    end

    assign m_valid = ~|empty;
    assign pop     = m_valid & (&m_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + PTR_ONE;
                if (pop)     rd_ptr[k] <= rd_ptr[k] + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (push[k]) mem[k][wr_ptr[k][AW-1:0]] <= {s_last[k], s_data[k]};
        end
    end

    // A mismatching pop outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlast_mismatch <= 1'b0;
            triple_cnt     <= '0;
        end else begin
            if (pop && (head_last != 3'b000) && (head_last != 3'b111))
                tlast_mismatch <= 1'b1;
            else if (err_clr)
                tlast_mismatch <= 1'b0;
            if (pop) triple_cnt <= sat_inc(triple_cnt);
        end
    end

    assign s_axis_0.tready = s_ready[0];
    assign s_axis_1.tready = s_ready[1];
    assign s_axis_2.tready = s_ready[2];

    assign m_axis_0.tvalid = m_valid;
    assign m_axis_1.tvalid = m_valid;
    assign m_axis_2.tvalid = m_valid;
    assign m_axis_0.tdata  = head[0][DATA_WIDTH-1:0];
    assign m_axis_1.tdata  = head[1][DATA_WIDTH-1:0];
    assign m_axis_2.tdata  = head[2][DATA_WIDTH-1:0];
    assign m_axis_0.tlast  = head_last[0];
    assign m_axis_1.tlast  = head_last[1];
    assign m_axis_2.tlast  = head_last[2];

endmodule

// File: doc/axis_vote_aligner.md
AXIS_VOTE_ALIGNER -- requirements
Module: axis_vote_aligner

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of every tdata bus.
REQ-002 Parameter FIFO_DEPTH, default 4: entries per lane FIFO; power of two, >= 2.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_axis_tdata_k  input  DATA_WIDTH  classifier k result, k = 0,1,2.
REQ-006 s_axis_tvalid_k  input  1  classifier k valid.
REQ-007 s_axis_tready_k  output  1  lane k can accept a beat.
REQ-008 s_axis_tlast_k  input  1  classifier k end-of-frame marker.
REQ-009 m_axis_tdata_k  output  DATA_WIDTH  aligned result k, to the majority-vote stage.
REQ-010 m_axis_tvalid_k  output  1  aligned triple available; identical value on all three k.
REQ-011 m_axis_tready_k  input  1  downstream ready for lane k.
REQ-012 m_axis_tlast_k  output  1  tlast stored with the head entry of lane k.
REQ-013 err_clr  input  1  synchronous clear of tlast_mismatch.
REQ-014 tlast_mismatch  output  1  sticky flag: a popped triple had unequal tlast bits.
REQ-015 triple_cnt  output  16  number of triples popped since reset, saturating.

Function
REQ-016 Each lane k SHALL hold an independent FIFO of FIFO_DEPTH entries storing {tlast, tdata}.
- Read/write pointers: log2(FIFO_DEPTH)+1 bits, wrapping modulo 2*FIFO_DEPTH.
REQ-017 s_axis_tready_k SHALL be 1 iff lane k is not full and rst_n is high.
- No full-FIFO pass-through: a full lane SHALL NOT accept a beat even in a cycle in which it pops.
REQ-018 Push k SHALL occur on a rising edge with s_axis_tvalid_k && s_axis_tready_k; data SHALL be written at the write pointer, and the write pointer SHALL advance by 1.
REQ-019 m_axis_tvalid_k SHALL be 1 iff all three lanes are non-empty.
REQ-020 m_axis_tdata_k and m_axis_tlast_k SHALL be driven from the lane-k head entry.
- Values are don't-care while m_axis_tvalid is 0.
REQ-021 A pop SHALL occur iff m_axis_tvalid && m_axis_tready_0 && m_axis_tready_1 && m_axis_tready_2.
- A pop advances all three read pointers together.
- No lane ever pops alone.
REQ-022 Latency: a beat pushed at edge N SHALL be visible at the lane head after edge N, i.e. in cycle N+1. There is no combinational path from s_axis to m_axis.
REQ-023 Simultaneous push and pop on a non-full, non-empty lane SHALL leave its occupancy unchanged.
REQ-024 Head data and m_axis_tvalid SHALL remain stable while m_axis_tvalid=1 and no pop occurs.
REQ-025 On every pop where the three head tlast bits are not all equal, tlast_mismatch SHALL be set to 1 at that edge.
REQ-026 err_clr=1 SHALL clear tlast_mismatch at the next edge.
- If a mismatching pop coincides with err_clr, set wins and the flag stays 1.
REQ-027 triple_cnt SHALL increment by 1 on each pop and saturate at 0xFFFF.
REQ-028 Data in FIFO storage SHALL NOT be modified except by a push.

Reset
REQ-029 While rst_n=0, the block SHALL hold:
- all pointers 0 (all lanes empty);
- s_axis_tready_k=0;
- m_axis_tvalid_k=0;
- tlast_mismatch=0;
- triple_cnt=0.
REQ-030 Reset assertion mid-operation SHALL discard all buffered entries immediately.
REQ-031 On the first cycle after rst_n rises, s_axis_tready_k SHALL be 1.
REQ-032 FIFO storage contents need not be reset.

Verification
REQ-033 Skewed arrival: lane0 pushes 0xA at cycle 0, lane1 pushes 0xB at cycle 2, lane2 pushes 0xC at cycle 5, all m_tready=1 -> m_tvalid first 1 in cycle 6 with tdata {0xA,0xB,0xC}, popped that cycle, triple_cnt=1.
REQ-034 Fill: push 4 beats on lane0 only, all m_tready=1 -> s_tready_0=0 after the 4th push, m_tvalid stays 0. Then push one beat each on lanes 1 and 2 -> one pop, and s_tready_0=1 the following cycle.
REQ-035 Backpressure: 3 triples buffered, m_tready_1 held 0 for 10 cycles -> no pop, head data stable. Release -> 3 consecutive pops in order, triple_cnt=3.
REQ-036 Tlast mismatch: pop a triple with tlast {1,0,1} -> tlast_mismatch=1. Pulse err_clr alone -> 0. Pulse err_clr in the same cycle as a second mismatching pop -> remains 1.
REQ-037 Reset mid-stream: 2 entries per lane buffered, rst_n pulsed low -> m_tvalid=0 and triple_cnt=0 immediately. After release, the old data never appears.
REQ-038 Saturation and wrap: 70000 triples streamed at full rate -> triple_cnt=0xFFFF, data order preserved across pointer wrap on every lane.
